// File: rtl/game_board_controller_pkg.sv
// Shared encodings for the tic-tac-toe board controller and its display side:
// cell codes, marks, FSM states, the eight winning lines and cursor movement.
package game_board_controller_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    localparam logic [1:0] MARK_EMPTY = 2'd0;
    localparam logic [1:0] MARK_CROSS = 2'd1;
    localparam logic [1:0] MARK_ZERO  = 2'd2;

    typedef logic [8:0][1:0] board_t;

    localparam logic [3:0] CELL_CROSS     = 4'd0;
    localparam logic [3:0] CELL_ZERO      = 4'd1;
    localparam logic [3:0] CELL_EMPTY     = 4'd2;
    localparam logic [3:0] CELL_CROSS_CUR = 4'd3;
    localparam logic [3:0] CELL_ZERO_CUR  = 4'd4;
    localparam logic [3:0] CELL_EMPTY_CUR = 4'd5;
    localparam logic [3:0] CELL_WIN_CROSS = 4'd6;
    localparam logic [3:0] CELL_WIN_ZERO  = 4'd7;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_CROSS = 2'b01;
    localparam logic [1:0] WIN_ZERO  = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    localparam logic [3:0]  CURSOR_HOME = 4'd4;
    localparam logic [35:0] CTRL_RESET  = 36'h222252222;

    // Bit i of each entry marks cell i (i = row*3 + col) as part of that line.
    localparam logic [8:0] LINE_MASK [8] = '{
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    function automatic logic [3:0] move_cursor(input logic [3:0] idx, input dir_e dir,
                                               input logic wrap);
        logic [3:0] row;
        logic [3:0] col;
        row = idx / 4'd3;
        col = idx % 4'd3;
        case (dir)
            DIR_UP:    begin if (row != 4'd0) row = row - 4'd1; else if (wrap) row = 4'd2; end
            DIR_DOWN:  begin if (row != 4'd2) row = row + 4'd1; else if (wrap) row = 4'd0; end
            DIR_LEFT:  begin if (col != 4'd0) col = col - 4'd1; else if (wrap) col = 4'd2; end
            DIR_RIGHT: begin if (col != 4'd2) col = col + 4'd1; else if (wrap) col = 4'd0; end
        endcase
        return row * 4'd3 + col;
    endfunction

endpackage

// File: rtl/win_checker.sv
// Combinational line evaluation: flags which of the eight lines are fully
// occupied by the given mark.
module win_checker
    import game_board_controller_pkg::*;
(
    input  board_t      board,
    input  logic [1:0]  mark,
    output logic        win,
    output logic [7:0]  line_mask
);

    always_comb begin
        line_mask = '0;
        for (int l = 0; l < 8; l++) begin
            line_mask[l] = 1'b1;
            for (int c = 0; c < 9; c++) begin
                if (LINE_MASK[l][c] && board[c] != mark) line_mask[l] = 1'b0;
            end
        end
        win = |line_mask;
    end

endmodule

// File: rtl/game_board_controller.sv
// Tic-tac-toe board controller: cursor, mark placement, win/draw detection
// and a registered 36-bit cell-code array for the display.
module game_board_controller
    import game_board_controller_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0,
    parameter logic WRAP_CURSOR  = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic        BTN_LEFT,
    input  logic        BTN_RIGHT,
    input  logic        BTN_SEL,
    output logic [35:0] CONTROL_ARRAY,
    output logic        TURN,
    output logic        GAME_OVER,
    output logic [1:0]  WINNER,
    output logic [1:0]  dbg_state
);

    state_e      state_q, state_d;
    board_t      board_q, board_d;
    logic [3:0]  cursor_q, cursor_d;
    logic [3:0]  moves_q, moves_d;
    logic        turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;
    logic [35:0] ctrl_q, ctrl_d;
    logic        turn_out_q, turn_out_d;
    logic        over_q, over_d;
    logic [1:0]  winner_out_q, winner_out_d;

    logic [1:0]  mover_mark;
    logic        win;
    logic [7:0]  line_mask;
    logic [8:0]  win_cells;

    // The mover's turn is held through CHECK and OVER, so this also picks the winner's lines.
    assign mover_mark = turn_q ? MARK_ZERO : MARK_CROSS;

    win_checker u_win_checker (
        .board     (board_q),
        .mark      (mover_mark),
        .win       (win),
        .line_mask (line_mask)
    );

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        cursor_d = cursor_q;
        moves_d  = moves_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        case (state_q)
            ST_PLAY: begin
                if (BTN_SEL) begin
                    if (board_q[cursor_q] == MARK_EMPTY) begin
                        board_d[cursor_q] = mover_mark;
                        moves_d           = moves_q + 4'd1;
                        state_d           = ST_CHECK;
                    end
                end else if (BTN_UP) begin
                    cursor_d = move_cursor(cursor_q, DIR_UP, WRAP_CURSOR);
                end else if (BTN_DOWN) begin
                    cursor_d = move_cursor(cursor_q, DIR_DOWN, WRAP_CURSOR);
                end else if (BTN_LEFT) begin
                    cursor_d = move_cursor(cursor_q, DIR_LEFT, WRAP_CURSOR);
                end else if (BTN_RIGHT) begin
                    cursor_d = move_cursor(cursor_q, DIR_RIGHT, WRAP_CURSOR);
                end
            end
            ST_CHECK: begin
                if (win) begin
                    winner_d = turn_q ? WIN_ZERO : WIN_CROSS;
                    state_d  = ST_OVER;
                end else if (moves_q == 4'd9) begin
                    winner_d = WIN_DRAW;
                    state_d  = ST_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (BTN_SEL) begin
                    board_d  = '0;
                    moves_d  = '0;
                    winner_d = WIN_NONE;
                    cursor_d = CURSOR_HOME;
                    turn_d   = FIRST_PLAYER;
                    state_d  = ST_PLAY;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    always_comb begin : display_logic
        logic [3:0] code;
        logic       show_cursor;
        logic       show_win;
        win_cells = '0;
        for (int l = 0; l < 8; l++) begin
            if (line_mask[l]) win_cells = win_cells | LINE_MASK[l];
        end
        ctrl_d = '0;
        for (int i = 0; i < 9; i++) begin
            show_cursor = (state_q != ST_OVER) && (cursor_q == 4'(i));
            show_win    = (state_q == ST_OVER) && (winner_q != WIN_DRAW) && win_cells[i];
            case (board_q[i])
                MARK_CROSS: code = show_win ? CELL_WIN_CROSS : (show_cursor ? CELL_CROSS_CUR : CELL_CROSS);
                MARK_ZERO:  code = show_win ? CELL_WIN_ZERO  : (show_cursor ? CELL_ZERO_CUR  : CELL_ZERO);
                default:    code = show_cursor ? CELL_EMPTY_CUR : CELL_EMPTY;
            endcase
            ctrl_d[4*i +: 4] = code;
        end
        turn_out_d   = turn_q;
        over_d       = (state_q == ST_OVER);
        winner_out_d = winner_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_PLAY;
            board_q      <= '0;
            cursor_q     <= CURSOR_HOME;
            moves_q      <= '0;
            turn_q       <= FIRST_PLAYER;
            winner_q     <= WIN_NONE;
            ctrl_q       <= CTRL_RESET;
            turn_out_q   <= FIRST_PLAYER;
            over_q       <= 1'b0;
            winner_out_q <= WIN_NONE;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            cursor_q     <= cursor_d;
            moves_q      <= moves_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            ctrl_q       <= ctrl_d;
            turn_out_q   <= turn_out_d;
            over_q       <= over_d;
            winner_out_q <= winner_out_d;
        end
    end

    assign CONTROL_ARRAY = ctrl_q;
    assign TURN          = turn_out_q;
    assign GAME_OVER     = over_q;
    assign WINNER        = winner_out_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_game_board_controller.sv
// Bench for game_board_controller: two instances (cross-first/saturating and
// zero-first/wrapping) driven with identical button pulses.
module tb_game_board_controller;

    localparam logic [4:0] B_SEL   = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;
    localparam logic [35:0] CA_RESET = 36'h222252222;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, sel = 1'b0;
    logic [35:0] ca0, ca1;
    logic        t0, t1, go0, go1;
    logic [1:0]  w0, w1, st0, st1;

    game_board_controller #(.FIRST_PLAYER(1'b0), .WRAP_CURSOR(1'b0)) dut0 (
        .CLK(clk), .RESET(rst), .BTN_UP(up), .BTN_DOWN(down), .BTN_LEFT(left),
        .BTN_RIGHT(right), .BTN_SEL(sel), .CONTROL_ARRAY(ca0), .TURN(t0),
        .GAME_OVER(go0), .WINNER(w0), .dbg_state(st0)
    );

    game_board_controller #(.FIRST_PLAYER(1'b1), .WRAP_CURSOR(1'b1)) dut1 (
        .CLK(clk), .RESET(rst), .BTN_UP(up), .BTN_DOWN(down), .BTN_LEFT(left),
        .BTN_RIGHT(right), .BTN_SEL(sel), .CONTROL_ARRAY(ca1), .TURN(t1),
        .GAME_OVER(go1), .WINNER(w1), .dbg_state(st1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [39:0] exp_q[$];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] actual(input int d);
        return (d == 0) ? {ca0, t0, go0, w0} : {ca1, t1, go1, w1};
    endfunction

    // ---------------- reference model (game rules, per instance) ----------------
    int m_cell[2][9];   // 0 empty, 1 cross, 2 zero
    int m_row[2], m_col[2], m_turn[2], m_over[2], m_winner[2], m_moves[2];

    function automatic void model_reset(input int d);
        for (int i = 0; i < 9; i++) m_cell[d][i] = 0;
        m_row[d] = 1; m_col[d] = 1;
        m_turn[d] = d;          // instance 1 has zero moving first
        m_over[d] = 0; m_winner[d] = 0; m_moves[d] = 0;
    endfunction

    function automatic bit line_full(input int d, input int a, input int b, input int c, input int who);
        return m_cell[d][a] == who && m_cell[d][b] == who && m_cell[d][c] == who;
    endfunction

    function automatic bit on_winning_line(input int d, input int i, input int who);
        int r, c;
        r = i / 3; c = i % 3;
        if (line_full(d, 3*r, 3*r+1, 3*r+2, who)) return 1'b1;
        if (line_full(d, c, c+3, c+6, who)) return 1'b1;
        if (r == c && line_full(d, 0, 4, 8, who)) return 1'b1;
        if (r + c == 2 && line_full(d, 2, 4, 6, who)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit has_won(input int d, input int who);
        for (int i = 0; i < 9; i++) if (on_winning_line(d, i, who)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(input int d, input logic [4:0] b);
        int who, idx;
        bit wrap;
        who = m_turn[d] + 1;
        idx = m_row[d] * 3 + m_col[d];
        wrap = (d == 1);
        if (m_over[d] != 0) begin
            if (b[4]) model_reset(d);
        end else if (b[4]) begin
            if (m_cell[d][idx] == 0) begin
                m_cell[d][idx] = who;
                m_moves[d]++;
                if (has_won(d, who)) begin
                    m_over[d] = 1; m_winner[d] = who;
                end else if (m_moves[d] == 9) begin
                    m_over[d] = 1; m_winner[d] = 3;
                end else begin
                    m_turn[d] = 1 - m_turn[d];
                end
            end
        end else if (b[3]) begin
            if (m_row[d] > 0) m_row[d]--; else if (wrap) m_row[d] = 2;
        end else if (b[2]) begin
            if (m_row[d] < 2) m_row[d]++; else if (wrap) m_row[d] = 0;
        end else if (b[1]) begin
            if (m_col[d] > 0) m_col[d]--; else if (wrap) m_col[d] = 2;
        end else if (b[0]) begin
            if (m_col[d] < 2) m_col[d]++; else if (wrap) m_col[d] = 0;
        end
    endfunction

    function automatic logic [39:0] model_expect(input int d);
        logic [35:0] ca;
        int code;
        ca = '0;
        for (int i = 0; i < 9; i++) begin
            code = (m_cell[d][i] == 1) ? 0 : (m_cell[d][i] == 2) ? 1 : 2;
            if (m_over[d] == 0 && i == m_row[d] * 3 + m_col[d]) code += 3;
            if (m_over[d] != 0 && m_winner[d] != 3 && m_cell[d][i] != 0 &&
                on_winning_line(d, i, m_cell[d][i]))
                code = (m_cell[d][i] == 1) ? 6 : 7;
            ca[4*i +: 4] = 4'(code);
        end
        return {ca, 1'(m_turn[d]), 1'(m_over[d]), 2'(m_winner[d])};
    endfunction

    task automatic sb_check(input string name, input int d);
        logic [39:0] e;
        exp_q.push_back(model_expect(d));
        e = exp_q.pop_front();
        check(name, actual(d), e);
    endtask

    // ---------------- drivers ----------------
    task automatic pulse(input logic [4:0] b);
        @(negedge clk);
        {sel, up, down, left, right} = b;
        @(negedge clk);
        {sel, up, down, left, right} = 5'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input logic [4:0] b);
        pulse(b);
        model_step(0, b);
        model_step(1, b);
        idle(2);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_held_dut0", actual(0), {CA_RESET, 1'b0, 1'b0, 2'b00});
        check("reset_held_dut1", actual(1), {CA_RESET, 1'b1, 1'b0, 2'b00});
        @(negedge clk);
        rst = 1'b0;
        model_reset(0);
        model_reset(1);
    endtask

    // Moves both cursors toward the target without ever pushing past an edge.
    task automatic goto_cell(input int target);
        for (int g = 0; g < 6; g++) begin
            if (m_row[0] > target / 3)      step(B_UP);
            else if (m_row[0] < target / 3) step(B_DOWN);
            else if (m_col[0] > target % 3) step(B_LEFT);
            else if (m_col[0] < target % 3) step(B_RIGHT);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [4:0]  btns;
        logic [35:0] ca;
        logic        turn;
        logic        over;
        logic [1:0]  win;
    } vec_t;

    vec_t vecs[17];
    int   draw_seq[9] = '{0, 4, 8, 1, 7, 6, 2, 5, 3};

    initial begin
        vecs[0]  = '{B_LEFT,        36'h222225222, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{B_UP,          36'h222222225, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{B_UP,          36'h222222225, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{B_SEL,         36'h222222223, 1'b1, 1'b0, 2'd0};
        vecs[4]  = '{B_DOWN,        36'h222225220, 1'b1, 1'b0, 2'd0};
        vecs[5]  = '{B_SEL,         36'h222224220, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{B_UP,          36'h222221223, 1'b0, 1'b0, 2'd0};
        vecs[7]  = '{B_RIGHT,       36'h222221250, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{B_SEL,         36'h222221230, 1'b1, 1'b0, 2'd0};
        vecs[9]  = '{B_DOWN,        36'h222251200, 1'b1, 1'b0, 2'd0};
        vecs[10] = '{B_UP | B_SEL,  36'h222241200, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{B_SEL,         36'h222241200, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{B_UP,          36'h222211230, 1'b0, 1'b0, 2'd0};
        vecs[13] = '{B_RIGHT,       36'h222211500, 1'b0, 1'b0, 2'd0};
        vecs[14] = '{B_SEL,         36'h222211666, 1'b0, 1'b1, 2'd1};
        vecs[15] = '{B_LEFT,        36'h222211666, 1'b0, 1'b1, 2'd1};
        vecs[16] = '{B_SEL,         CA_RESET,      1'b0, 1'b0, 2'd0};

        // Reset asserted from a rising edge so the asynchronous clear fires.
        #1 rst = 1'b1;
        #2;
        check("reset_held_dut0", actual(0), {CA_RESET, 1'b0, 1'b0, 2'b00});
        check("reset_held_dut1", actual(1), {CA_RESET, 1'b1, 1'b0, 2'b00});
        @(negedge clk);
        rst = 1'b0;
        model_reset(0);
        model_reset(1);
        idle(2);
        check("post_reset_dut0", actual(0), {CA_RESET, 1'b0, 1'b0, 2'b00});
        check("post_reset_state", {38'b0, st0}, 40'd0);

        // Cursor edges, a cross win on the top row, ignored/priority selects, restart.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].btns);
            check($sformatf("vec%0d_dut0", i), actual(0),
                  {vecs[i].ca, vecs[i].turn, vecs[i].over, vecs[i].win});
            sb_check($sformatf("vec%0d_dut1", i), 1);
            if (i == 2) check("wrap_up_dut1", {4'b0, ca1}, {4'b0, 36'h225222222});
        end

        // Draw game with exact latency checks on the first and last selects.
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            goto_cell(draw_seq[k]);
            if (k == 0) begin
                pulse(B_SEL);
                model_step(0, B_SEL);
                model_step(1, B_SEL);
                check("mark_not_yet_visible", {4'b0, ca0}, {4'b0, 36'h222222225});
                idle(1);
                check("mark_visible", {4'b0, ca0}, {4'b0, 36'h222222223});
                idle(1);
            end else if (k == 8) begin
                pulse(B_SEL);
                model_step(0, B_SEL);
                model_step(1, B_SEL);
                idle(1);
                check("over_not_yet", {39'b0, go0}, 40'd0);
                idle(1);
                check("draw_dut0", actual(0), {36'h001110010, 1'b0, 1'b1, 2'b11});
                check("draw_dut1", actual(1), {36'h110001101, 1'b1, 1'b1, 2'b11});
            end else begin
                step(B_SEL);
            end
            sb_check($sformatf("draw%0d_dut0", k), 0);
            sb_check($sformatf("draw%0d_dut1", k), 1);
        end
        step(B_SEL);
        check("restart_dut0", actual(0), {CA_RESET, 1'b0, 1'b0, 2'b00});
        check("restart_dut1", actual(1), {CA_RESET, 1'b1, 1'b0, 2'b00});

        // Reset asserted while in CHECK must clear outputs before any clock edge.
        goto_cell(0);
        @(negedge clk);
        sel = 1'b1;
        @(posedge clk);
        #1 sel = 1'b0;
        check("in_check_state", {38'b0, st0}, 40'd1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_dut0", actual(0), {CA_RESET, 1'b0, 1'b0, 2'b00});
        check("async_reset_dut1", actual(1), {CA_RESET, 1'b1, 1'b0, 2'b00});
        check("async_reset_state", {38'b0, st0}, 40'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset(0);
        model_reset(1);

        // Random button traffic against the rule model.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] b;
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      b = B_SEL;
            else if (r < 8) b = 5'(1 << $urandom_range(0, 3));
            else            b = 5'($urandom_range(1, 31));
            step(b);
            sb_check($sformatf("rand%0d_dut0", n), 0);
            sb_check($sformatf("rand%0d_dut1", n), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/game_board_controller.md
GAME_BOARD_CONTROLLER -- requirements
Module: game_board_controller

Interface
REQ-001 Parameter FIRST_PLAYER, default 0, sets who moves first after reset/restart: 0 = cross, 1 = zero.
REQ-002 Parameter WRAP_CURSOR, default 0, sets cursor behaviour at the board edge: 0 = saturate, 1 = wrap within the row/column.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  reset, asynchronous and active-high.
REQ-005 BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT  input  1 each  single-cycle, already-debounced cursor-move pulses.
REQ-006 BTN_SEL  input  1  single-cycle pulse: place a mark, or restart when the game is over.
REQ-007 CONTROL_ARRAY  output  36  nine 4-bit cell codes; cell i occupies bits [4i+3:4i]; i = row*3 + col, with row 0 at the top.
REQ-008 TURN  output  1  player to move: 0 = cross, 1 = zero.
REQ-009 GAME_OVER  output  1  high while the game is finished.
REQ-010 WINNER  output  2  result: 00 none, 01 cross, 10 zero, 11 draw.

Function
REQ-011 Cell codes SHALL be: 0 cross, 1 zero, 2 empty, 3 cross+cursor, 4 zero+cursor, 5 empty+cursor, 6 winning cross, 7 winning zero; 8-15 are never driven (15 is reserved for the display's black band).
REQ-012 The block SHALL hold internal state as follows: board of nine 2-bit marks (empty/cross/zero); cursor index 0..8; move counter 0..9; FSM states PLAY, CHECK, OVER.
REQ-013 In PLAY, at most one button SHALL be acted on per cycle, in priority order SEL > UP > DOWN > LEFT > RIGHT; lower-priority pulses in the same cycle are discarded.
REQ-014 Cursor moves SHALL change the row or column by 1; at an edge the cursor holds when WRAP_CURSOR=0 and wraps to the opposite edge of the same row/column when WRAP_CURSOR=1.
REQ-015 In PLAY, BTN_SEL on an empty cell SHALL write the TURN mark and increment the move counter, and the FSM SHALL enter CHECK on the next edge.
REQ-016 In PLAY, BTN_SEL on an occupied cell SHALL be ignored: no state change.
REQ-017 CHECK SHALL last exactly one cycle and evaluate all 8 lines for the mover's mark: on a win, go to OVER with WINNER = mover; else, if the move counter is 9, go to OVER with WINNER = 11; else toggle TURN and return to PLAY.
REQ-018 All buttons SHALL be ignored while the FSM is in CHECK.
REQ-019 In OVER, only BTN_SEL SHALL act: it clears the board, counter and WINNER, sets cursor=4 and TURN=FIRST_PLAYER, and enters PLAY.
REQ-020 CONTROL_ARRAY SHALL be registered and SHALL reflect a state change one cycle after the state register updates; a placed mark is therefore visible 2 cycles after the BTN_SEL edge.
REQ-021 The cursor overlay (codes 3-5) SHALL be shown only in PLAY and CHECK.
REQ-022 In OVER, cells of the winning line(s) SHALL show codes 6/7 and all other cells their plain codes; on a draw, all cells SHALL show plain codes.
REQ-023 GAME_OVER SHALL equal (state == OVER), driven from a register.

Reset
REQ-024 RESET SHALL asynchronously clear the board to empty and set cursor=4, move counter=0, TURN=FIRST_PLAYER, state=PLAY, GAME_OVER=0 and WINNER=00.
REQ-025 While RESET is asserted, CONTROL_ARRAY SHALL read cell 4 = 5 and all other cells = 2.
REQ-026 A RESET assertion during CHECK or OVER SHALL abort the game with no residual state.

Structure
REQ-027 A shared package SHALL hold the cell-code constants, the mark encoding, the FSM state encoding and the 8-entry line table, so the display side uses the same codes.
REQ-028 A single sub-module, win_checker, SHALL be combinational: it takes the board and a mark, and returns a win flag plus an 8-bit winning-line mask.

Verification
REQ-029 Reset release with no buttons pressed -> CONTROL_ARRAY = 0x222252222 (cell 4 = 5), TURN=0, GAME_OVER=0.
REQ-030 From reset, LEFT pulse then UP pulse -> cursor=0; a further UP pulse holds cursor=0 with WRAP_CURSOR=0 and moves it to 6 with WRAP_CURSOR=1.
REQ-031 Cross places cells 0, 1, 2 while zero places cells 3, 4 -> GAME_OVER=1 and WINNER=01 three cycles after the last SEL; cells 0-2 show code 6.
REQ-032 SEL on an occupied cell, and UP+SEL pulsed in the same cycle on an empty cell -> first: no change; second: mark placed, cursor unmoved.
REQ-033 Nine alternating moves with no line completed -> WINNER=11, no codes 6/7 shown; a subsequent SEL restarts with an empty board and TURN=FIRST_PLAYER.
REQ-034 RESET asserted in CHECK -> outputs reach their reset values without waiting for a clock edge.
